// File: rtl/fir_serial_mac_if.sv
// Handshake and result bundle for fir_serial_mac: coefficient load, sample input, result output.
// The master side drives requests; the slave side is the filter core.
interface fir_serial_mac_if #(
    parameter int BW_IN   = 6,
    parameter int BW_COEF = 6,
    parameter int BW_OUT  = 8
);
    logic                      coef_load;
    logic                      coef_valid;
    logic signed [BW_COEF-1:0] coef_in;
    logic                      x_valid;
    logic signed [BW_IN-1:0]   x_in;
    logic                      x_ready;
    logic                      y_valid;
    logic signed [BW_OUT-1:0]  y_out;
    logic                      busy;

    modport master (
        output coef_load, coef_valid, coef_in, x_valid, x_in,
        input  x_ready, y_valid, y_out, busy
    );

    modport slave (
        input  coef_load, coef_valid, coef_in, x_valid, x_in,
        output x_ready, y_valid, y_out, busy
    );
endinterface

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR core: one shared multiply-accumulate walks all taps per sample.
// Optional output saturation is enabled by defining FIR_SATURATE_EN; otherwise the output wraps.
module fir_serial_mac #(
    parameter int N_TAPS  = 5,
    parameter int BW_IN   = 6,
    parameter int BW_COEF = 6,
    parameter int BW_ACC  = 15,
    parameter int BW_OUT  = 8,
    parameter int SHIFT   = 0
) (
    input  logic            clk,
    input  logic            reset,
    fir_serial_mac_if.slave bus
);
    localparam int IDX_W  = $clog2(N_TAPS);
    localparam int PROD_W = BW_IN + BW_COEF;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic signed [BW_COEF-1:0] coef_q [N_TAPS];
    logic signed [BW_COEF-1:0] coef_d [N_TAPS];
    logic signed [BW_IN-1:0]   x_q    [N_TAPS];
    logic signed [BW_IN-1:0]   x_d    [N_TAPS];
    logic signed [BW_ACC-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic signed [BW_OUT-1:0]  y_out_q, y_out_d;
    logic                      y_valid_q, y_valid_d;

    logic signed [PROD_W-1:0]  x_ext_s;
    logic signed [PROD_W-1:0]  c_ext_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [BW_ACC-1:0]  shifted_s;

    // Reduce the shifted accumulator to the output width (clamp or two's-complement wrap).
    function automatic logic signed [BW_OUT-1:0] scale_f(input logic signed [BW_ACC-1:0] v);
`ifdef FIR_SATURATE_EN
        logic [BW_ACC-BW_OUT:0] hi;
        hi = v[BW_ACC-1:BW_OUT-1];
        if ((&hi) || !(|hi)) begin
            scale_f = v[BW_OUT-1:0];
        end else if (v[BW_ACC-1]) begin
            scale_f = {1'b1, {(BW_OUT-1){1'b0}}};
        end else begin
            scale_f = {1'b0, {(BW_OUT-1){1'b1}}};
        end
`else
        scale_f = v[BW_OUT-1:0];
`endif
    endfunction

    assign x_ext_s   = PROD_W'(x_q[idx_q]);
    assign c_ext_s   = PROD_W'(coef_q[idx_q]);
    assign prod_s    = x_ext_s * c_ext_s;
    assign shifted_s = acc_q >>> SHIFT;

    assign bus.x_ready = (state_q == ST_IDLE) & ~bus.coef_load;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;

    // Next-state and datapath updates for the load / accept / accumulate / emit sequence.
    always_comb begin
        state_d   = state_q;
        coef_d    = coef_q;
        x_d       = x_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        y_out_d   = y_out_q;
        y_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Load request takes priority over a pending sample.
                if (bus.coef_load) begin
                    state_d = ST_LOAD;
                    cnt_d   = IDX_W'(0);
                    for (int k = 0; k < N_TAPS; k++) begin
                        x_d[k] = BW_IN'(0);
                    end
                end else if (bus.x_valid) begin
                    state_d = ST_MAC;
                    for (int k = 1; k < N_TAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    x_d[0] = bus.x_in;
                    acc_d  = BW_ACC'(0);
                    idx_d  = IDX_W'(0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.coef_valid) begin
                    for (int k = 1; k < N_TAPS; k++) begin
                        coef_d[k] = coef_q[k-1];
                    end
                    coef_d[0] = bus.coef_in;
                    cnt_d     = cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + BW_ACC'(prod_s);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MAC;
                end
            end
            ST_DONE: begin
                y_out_d   = scale_f(shifted_s);
                y_valid_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= BW_ACC'(0);
            idx_q     <= IDX_W'(0);
            cnt_q     <= IDX_W'(0);
            y_out_q   <= BW_OUT'(0);
            y_valid_q <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                coef_q[k] <= BW_COEF'(0);
                x_q[k]    <= BW_IN'(0);
            end
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
            for (int k = 0; k < N_TAPS; k++) begin
                coef_q[k] <= coef_d[k];
                x_q[k]    <= x_d[k];
            end
        end
    end
endmodule

// File: tb/tb_fir_serial_mac.sv
// Randomized self-checking bench for fir_serial_mac against an arithmetic convolution model.
module tb_fir_serial_mac;
    localparam int N_TAPS  = 5;
    localparam int BW_IN   = 6;
    localparam int BW_COEF = 6;
    localparam int BW_ACC  = 15;
    localparam int BW_OUT  = 8;
    localparam int SHIFT   = 0;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    int m_coef [N_TAPS];
    int m_hist [N_TAPS];

    fir_serial_mac_if #(.BW_IN(BW_IN), .BW_COEF(BW_COEF), .BW_OUT(BW_OUT)) bus ();

    fir_serial_mac #(
        .N_TAPS(N_TAPS), .BW_IN(BW_IN), .BW_COEF(BW_COEF),
        .BW_ACC(BW_ACC), .BW_OUT(BW_OUT), .SHIFT(SHIFT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap_signed(input int v, input int bits);
        int m;
        int r;
        m = 1 << bits;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // y[n] = sum coef[k] * x[n-k], wrapped to the accumulator, shifted, reduced to output width.
    function automatic int model_y();
        int s;
        int a;
        s = 0;
        for (int k = 0; k < N_TAPS; k++) s += m_coef[k] * m_hist[k];
        a = wrap_signed(s, BW_ACC);
        a = a >>> SHIFT;
`ifdef FIR_SATURATE_EN
        if (a > 127) a = 127;
        if (a < -128) a = -128;
        return a;
`else
        return wrap_signed(a, BW_OUT);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
        for (int k = 0; k < N_TAPS; k++) begin
            m_coef[k] = 0;
            m_hist[k] = 0;
        end
    endtask

    task automatic enter_load();
        bus.coef_load = 1'b1;
        tick();
        bus.coef_load = 1'b0;
        for (int k = 0; k < N_TAPS; k++) m_hist[k] = 0;
    endtask

    task automatic feed_coefs(input int vals [N_TAPS]);
        for (int i = 0; i < N_TAPS; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            bus.coef_valid = 1'b1;
            bus.coef_in    = BW_COEF'(vals[i]);
            tick();
            bus.coef_valid = 1'b0;
            for (int k = N_TAPS - 1; k > 0; k--) m_coef[k] = m_coef[k-1];
            m_coef[0] = vals[i];
        end
    endtask

    task automatic load_coefs(input int vals [N_TAPS]);
        enter_load();
        feed_coefs(vals);
    endtask

    // Pushes one sample and waits (bounded) for its strobe; returns observations only.
    task automatic run_sample(input int xv, input bit poke_load, output int yv, output int lat,
                              output int low_cnt, output bit ready_at_strobe, output bit held);
        int   w;
        logic signed [BW_OUT-1:0] prev;
        w = 0;
        prev = bus.y_out;
        held = 1'b1;
        lat = -1;
        low_cnt = 0;
        ready_at_strobe = 1'b0;
        yv = 0;
        while (!bus.x_ready && w < 20) begin
            tick();
            w++;
        end
        bus.x_valid = 1'b1;
        bus.x_in    = BW_IN'(xv);
        tick();
        bus.x_valid = 1'b0;
        for (int k = N_TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = wrap_signed(xv, BW_IN);
        for (int k = 0; k < 30; k++) begin
            if (bus.y_valid) begin
                lat = k;
                yv = bus.y_out;
                ready_at_strobe = bus.x_ready;
                break;
            end
            if (bus.y_out !== prev) held = 1'b0;
            if (!bus.x_ready) low_cnt++;
            if (poke_load) bus.coef_load = (k == 2);
            tick();
        end
        bus.coef_load = 1'b0;
    endtask

    task automatic test_reset();
        bus.coef_load = 1'b0; bus.coef_valid = 1'b0; bus.coef_in = '0;
        bus.x_valid = 1'b0; bus.x_in = '0;
        do_reset(3);
        n_checks++; if (bus.y_out !== 8'sd0) begin n_fail++; $display("FAIL reset_y_out got %0d expected 0", bus.y_out); end
        n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid got %b expected 0", bus.y_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        n_checks++; if (bus.x_ready !== 1'b1) begin n_fail++; $display("FAIL reset_x_ready got %b expected 1", bus.x_ready); end
    endtask

    task automatic test_impulse();
        int coefs [N_TAPS] = '{1, 2, 3, 4, 5};
        int exp_y [6] = '{5, 4, 3, 2, 1, 0};
        int xs    [6] = '{1, 0, 0, 0, 0, 0};
        int yv, lat, low; bit rdy, held;
        load_coefs(coefs);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_end got %b expected 0", bus.busy); end
        for (int i = 0; i < 6; i++) begin
            run_sample(xs[i], 1'b0, yv, lat, low, rdy, held);
            n_checks++; if (yv !== exp_y[i]) begin n_fail++; $display("FAIL impulse_y[%0d] got %0d expected %0d", i, yv, exp_y[i]); end
            n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL impulse_latency[%0d] got %0d expected 6", i, lat); end
            if (i == 0) begin
                n_checks++; if (low !== 6) begin n_fail++; $display("FAIL x_ready_low_cycles got %0d expected 6", low); end
                n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL x_ready_at_strobe got %b expected 1", rdy); end
                tick();
                n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL y_valid_width got %b expected 0", bus.y_valid); end
            end
        end
    endtask

    task automatic test_ignored_controls();
        int coefs [N_TAPS] = '{1, 2, 3, 4, 5};
        int exp_y [6] = '{5, 4, 3, 2, 1, 0};
        int xs    [6] = '{1, 0, 0, 0, 0, 0};
        int yv, lat, low; bit rdy, held;
        load_coefs(coefs);
        bus.coef_valid = 1'b1;
        bus.coef_in    = 6'sd7;
        tick();
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_coef_valid_busy got %b expected 0", bus.busy); end
        bus.coef_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_sample(xs[i], 1'b1, yv, lat, low, rdy, held);
            n_checks++; if (yv !== exp_y[i]) begin n_fail++; $display("FAIL ignored_y[%0d] got %0d expected %0d", i, yv, exp_y[i]); end
            n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL ignored_latency[%0d] got %0d expected 6", i, lat); end
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignored_busy_end got %b expected 0", bus.busy); end
    endtask

    task automatic test_random();
        int coefs [N_TAPS];
        int xv, yv, lat, low, expv; bit rdy, held;
        for (int k = 0; k < N_TAPS; k++) coefs[k] = int'($urandom_range(0, 63)) - 32;
        load_coefs(coefs);
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            xv = int'($urandom_range(0, 63)) - 32;
            run_sample(xv, 1'b0, yv, lat, low, rdy, held);
            expv = model_y();
            n_checks++; if (yv !== expv) begin n_fail++; $display("FAIL random_y[%0d] got %0d expected %0d", i, yv, expv); end
            n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL random_latency[%0d] got %0d expected 6", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        int xv, yv, lat, low, expv; bit rdy, held;
        for (int i = 0; i < 8; i++) begin
            xv = int'($urandom_range(0, 63)) - 32;
            run_sample(xv, 1'b0, yv, lat, low, rdy, held);
            expv = model_y();
            n_checks++; if (yv !== expv) begin n_fail++; $display("FAIL b2b_y[%0d] got %0d expected %0d", i, yv, expv); end
            n_checks++; if (lat !== 6 || rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_timing[%0d] got lat=%0d ready=%b expected lat=6 ready=1", i, lat, rdy); end
            n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL b2b_y_held[%0d] got %b expected 1", i, held); end
        end
    endtask

    task automatic test_overflow();
        int coefs [N_TAPS] = '{31, 31, 31, 31, 31};
        int yv, lat, low, expv, exp5; bit rdy, held;
`ifdef FIR_SATURATE_EN
        exp5 = 127;
`else
        exp5 = -59;
`endif
        load_coefs(coefs);
        for (int i = 0; i < 5; i++) begin
            run_sample(31, 1'b0, yv, lat, low, rdy, held);
            expv = model_y();
            n_checks++; if (yv !== expv) begin n_fail++; $display("FAIL overflow_y[%0d] got %0d expected %0d", i, yv, expv); end
        end
        n_checks++; if (yv !== exp5) begin n_fail++; $display("FAIL overflow_fifth got %0d expected %0d", yv, exp5); end
    endtask

    task automatic test_priority();
        int coefs [N_TAPS] = '{1, 2, 3, 4, 5};
        int exp_y [6] = '{5, 4, 3, 2, 1, 0};
        int xs    [6] = '{1, 0, 0, 0, 0, 0};
        int yv, lat, low; bit rdy, held;
        bus.coef_load = 1'b1;
        bus.x_valid   = 1'b1;
        bus.x_in      = 6'sd13;
        #1;
        n_checks++; if (bus.x_ready !== 1'b0) begin n_fail++; $display("FAIL priority_x_ready got %b expected 0", bus.x_ready); end
        tick();
        bus.coef_load = 1'b0;
        bus.x_valid   = 1'b0;
        for (int k = 0; k < N_TAPS; k++) m_hist[k] = 0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL priority_busy got %b expected 1", bus.busy); end
        feed_coefs(coefs);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL priority_busy_end got %b expected 0", bus.busy); end
        for (int i = 0; i < 6; i++) begin
            run_sample(xs[i], 1'b0, yv, lat, low, rdy, held);
            n_checks++; if (yv !== exp_y[i]) begin n_fail++; $display("FAIL priority_y[%0d] got %0d expected %0d", i, yv, exp_y[i]); end
        end
    endtask

    task automatic test_reset_mid_mac();
        int yv, lat, low, strobes; bit rdy, held;
        strobes = 0;
        bus.x_valid = 1'b1;
        bus.x_in    = 6'sd9;
        tick();
        bus.x_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < N_TAPS; k++) begin
            m_coef[k] = 0;
            m_hist[k] = 0;
        end
        for (int c = 0; c < 10; c++) begin
            if (bus.y_valid) strobes++;
            tick();
        end
        n_checks++; if (strobes !== 0) begin n_fail++; $display("FAIL abort_no_strobe got %0d expected 0", strobes); end
        n_checks++; if (bus.y_out !== 8'sd0) begin n_fail++; $display("FAIL abort_y_out got %0d expected 0", bus.y_out); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b expected 0", bus.busy); end
        run_sample(int'($urandom_range(1, 31)), 1'b0, yv, lat, low, rdy, held);
        n_checks++; if (yv !== 0 || lat !== 6) begin n_fail++; $display("FAIL abort_next got y=%0d lat=%0d expected y=0 lat=6", yv, lat); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        test_reset();
        test_impulse();
        test_ignored_controls();
        test_random();
        test_back_to_back();
        test_overflow();
        test_priority();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
